// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard scoreboard.
// Entry layout, flush FSM states and fixed encodings.
package pipe_pkg;

  // Widest register address a scoreboard entry can hold;
  // narrower addresses are zero-extended on entry.
  localparam int WS_MAX_W = 8;

  // Forward-select code meaning "read the register file".
  localparam int FWD_RF = 0;

  // Hard-wired zero register; never a real dependency.
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic                valid;
    logic [WS_MAX_W-1:0] ws;
    logic                is_load;
  } sb_entry_t;

  typedef enum logic {
    RUN,
    FLUSH
  } flush_state_t;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage request and hazard-response bundle.
// master drives the ID view, slave is the hazard unit.
interface hazard_scoreboard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_W      = 2,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_re1;
  logic                  id_re2;
  logic                  id_we;
  logic [REG_ADDR_W-1:0] id_ws;
  logic                  id_is_load;
  logic                  ex_branch_taken;
  logic                  cnt_clr;

  logic                  stall;
  logic                  bubble;
  logic                  flush_ifid;
  logic [FWD_W-1:0]      fwd_a;
  logic [FWD_W-1:0]      fwd_b;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_re1, id_re2,
    output id_we, id_ws, id_is_load,
    output ex_branch_taken, cnt_clr,
    input  stall, bubble, flush_ifid,
    input  fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_re1, id_re2,
    input  id_we, id_ws, id_is_load,
    input  ex_branch_taken, cnt_clr,
    output stall, bubble, flush_ifid,
    output fwd_a, fwd_b, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear wins over increment; counting stops at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count events, hold at all-ones, clear on request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard hazard unit: stall/bubble/flush and forward selects.
// Optional macro HAZARD_FORWARDING_EN enables operand forwarding.
module hazard_scoreboard_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int SB_DEPTH     = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  hazard_scoreboard_unit_if.slave  bus
);

  localparam int FWD_W = $clog2(SB_DEPTH + 1);

  // entry 0 = EXE, then MEM, WB ...
  sb_entry_t [SB_DEPTH-1:0] sb;

  logic [SB_DEPTH-1:0] m_a;
  logic [SB_DEPTH-1:0] m_b;

  logic [WS_MAX_W-1:0] rs_x;
  logic [WS_MAX_W-1:0] rt_x;
  logic [WS_MAX_W-1:0] ws_x;
  logic [WS_MAX_W-1:0] zero_x;

  flush_state_t state;
  flush_state_t state_nx;
  logic [3:0]   fcnt;
  logic [3:0]   fcnt_nx;

  logic flushing;
  logic br_accept;
  logic hazard;
  logic stall;
  logic bubble;
  logic ins_ok;

  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;

  assign rs_x   = WS_MAX_W'(bus.id_rs);
  assign rt_x   = WS_MAX_W'(bus.id_rt);
  assign ws_x   = WS_MAX_W'(bus.id_ws);
  assign zero_x = WS_MAX_W'(REG_ZERO);

  // Match each ID source against every in-flight writer
  always_comb begin
    m_a = '0;
    m_b = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      m_a[k] = bus.id_valid && bus.id_re1 &&
               (rs_x != zero_x) && sb[k].valid &&
               (sb[k].ws == rs_x);
      m_b[k] = bus.id_valid && bus.id_re2 &&
               (rt_x != zero_x) && sb[k].valid &&
               (sb[k].ws == rt_x);
    end
  end

`ifdef HAZARD_FORWARDING_EN
  // Youngest producer (lowest entry) supplies the operand
  function automatic logic [FWD_W-1:0] pick(
    input logic [SB_DEPTH-1:0] m
  );
    pick = FWD_W'(FWD_RF);
    for (int k = SB_DEPTH - 1; k >= 0; k--) begin
      if (m[k]) pick = FWD_W'(k + 1);
    end
  endfunction

  // Only a load still in EXE has no data to forward yet
  assign hazard = (m_a[0] | m_b[0]) & sb[0].is_load;
  assign fwd_a  = pick(m_a);
  assign fwd_b  = pick(m_b);
`else
  logic unused_ld;

  // No bypass network: any pending writer blocks the reader
  assign hazard    = (|m_a) | (|m_b);
  assign fwd_a     = FWD_W'(FWD_RF);
  assign fwd_b     = FWD_W'(FWD_RF);
  assign unused_ld = sb[SB_DEPTH-1].is_load;
`endif

  // Flush state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
    end
  end

  // Branch acceptance and multi-cycle flush sequencing
  always_comb begin
    state_nx  = state;
    fcnt_nx   = fcnt;
    flushing  = 1'b0;
    br_accept = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.ex_branch_taken) begin
          flushing  = 1'b1;
          br_accept = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nx = FLUSH;
            fcnt_nx  = 4'(FLUSH_CYCLES - 1);
          end
        end
      end
      FLUSH: begin
        flushing = 1'b1;
        if (fcnt <= 4'd1) begin
          state_nx = RUN;
        end else begin
          fcnt_nx = fcnt - 4'd1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  // Flush wins so the redirect PC is not frozen out
  assign stall  = hazard & ~flushing;
  assign bubble = stall | flushing;
  assign ins_ok = bus.id_valid & bus.id_we &
                  (ws_x != zero_x) & ~bubble;

  // Advance the scoreboard one stage per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb <= '0;
    end else begin
      for (int k = SB_DEPTH - 1; k > 0; k--) begin
        sb[k] <= sb[k-1];
      end
      sb[0] <= '{valid:   ins_ok,
                 ws:      ws_x,
                 is_load: bus.id_is_load};
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .clr   (bus.cnt_clr),
    .count (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_accept),
    .clr   (bus.cnt_clr),
    .count (bus.flush_cnt)
  );

  assign bus.stall      = stall;
  assign bus.bubble     = bubble;
  assign bus.flush_ifid = flushing;
  assign bus.fwd_a      = fwd_a;
  assign bus.fwd_b      = fwd_b;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench for hazard_scoreboard_unit.
// Reference model tracks writes by issue cycle.
module tb_hazard_scoreboard_unit;

  localparam int RW   = 5;
  localparam int SBD  = 3;
  localparam int FC   = 2;
  localparam int CW   = 3;
  localparam int FW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(
    .REG_ADDR_W(RW), .FWD_W(FW), .CNT_W(CW)
  ) bus ();

  hazard_scoreboard_unit #(
    .REG_ADDR_W(RW), .SB_DEPTH(SBD),
    .FLUSH_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int c;
    int ws;
    bit ld;
  } wr_t;

  typedef struct {
    int cy;
    bit stall;
    bit bubble;
    bit flush;
    int fa;
    int fb;
    int sc;
    int fc;
  } exp_t;

  wr_t  q_wr[$];
  exp_t expq[$];

  int cyc        = 0;
  int flush_left = 0;
  int m_sc       = 0;
  int m_fc       = 0;
  int checks     = 0;
  int passes     = 0;

  // Age of the youngest in-flight writer of r, or -1
  function automatic int find_age(
    input int r, input bit rd, output bit ld
  );
    ld = 1'b0;
    if (!rd || r == 0) return -1;
    foreach (q_wr[i]) begin
      int age;
      age = cyc - q_wr[i].c - 1;
      if (age < SBD && q_wr[i].ws == r) begin
        ld = q_wr[i].ld;
        return age;
      end
    end
    return -1;
  endfunction

  task automatic step(
    input bit r, input bit v,
    input int rs, input int rt,
    input bit re1, input bit re2,
    input bit we, input int ws, input bit ld,
    input bit tk, input bit clr
  );
    exp_t e;
    int   aa, ab;
    bit   la, lb, hz, fl, acc;
    rst                 = r;
    bus.id_valid        = v;
    bus.id_rs           = RW'(rs);
    bus.id_rt           = RW'(rt);
    bus.id_re1          = re1;
    bus.id_re2          = re2;
    bus.id_we           = we;
    bus.id_ws           = RW'(ws);
    bus.id_is_load      = ld;
    bus.ex_branch_taken = tk;
    bus.cnt_clr         = clr;
    if (r) begin
      q_wr.delete();
      flush_left = 0;
      m_sc       = 0;
      m_fc       = 0;
    end
    aa = find_age(rs, v && re1, la);
    ab = find_age(rt, v && re2, lb);
    fl = (flush_left > 0) || tk;
`ifdef HAZARD_FORWARDING_EN
    hz   = (aa == 0 && la) || (ab == 0 && lb);
    e.fa = (aa < 0) ? 0 : aa + 1;
    e.fb = (ab < 0) ? 0 : ab + 1;
`else
    hz   = (aa >= 0) || (ab >= 0);
    e.fa = 0;
    e.fb = 0;
`endif
    e.cy     = cyc;
    e.stall  = hz && !fl;
    e.bubble = hz || fl;
    e.flush  = fl;
    e.sc     = m_sc;
    e.fc     = m_fc;
    expq.push_back(e);
    if (!r) begin
      acc = (flush_left == 0) && tk;
      if (clr) begin
        m_sc = 0;
        m_fc = 0;
      end else begin
        if (e.stall && m_sc < CMAX) m_sc++;
        if (acc && m_fc < CMAX) m_fc++;
      end
      if (flush_left > 0) flush_left--;
      else if (tk) flush_left = FC - 1;
      if (v && we && ws != 0 && !e.bubble)
        q_wr.push_front('{c: cyc, ws: ws, ld: ld});
    end
    cyc++;
    while (q_wr.size() > 0 &&
           cyc - q_wr[$].c - 1 >= SBD)
      void'(q_wr.pop_back());
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int ws, input bit ld);
    step(0, 1, 0, 0, 0, 0, 1, ws, ld, 0, 0);
  endtask

  task automatic rd(input int rs, input int rt);
    step(0, 1, rs, rt, 1, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(
    input string n, input int cy,
    input logic [31:0] act, input logic [31:0] want
  );
    checks++;
    if (act === want) begin
      passes++;
    end else begin
      $display("FAIL %s cyc=%0d got=%0d want=%0d",
               n, cy, act, want);
    end
  endtask

  // Monitor: compare DUT outputs with queued expectations
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("stall", e.cy, 32'(bus.stall), 32'(e.stall));
        chk("bubble", e.cy, 32'(bus.bubble), 32'(e.bubble));
        chk("flush_ifid", e.cy, 32'(bus.flush_ifid),
            32'(e.flush));
        chk("fwd_a", e.cy, 32'(bus.fwd_a), 32'(e.fa));
        chk("fwd_b", e.cy, 32'(bus.fwd_b), 32'(e.fb));
        chk("stall_cnt", e.cy, 32'(bus.stall_cnt),
            32'(e.sc));
        chk("flush_cnt", e.cy, 32'(bus.flush_cnt),
            32'(e.fc));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.id_valid = 1'b0;
    bus.id_rs = '0;
    bus.id_rt = '0;
    bus.id_re1 = 1'b0;
    bus.id_re2 = 1'b0;
    bus.id_we = 1'b0;
    bus.id_ws = '0;
    bus.id_is_load = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // add $3 then readers of $3
    wr(3, 0);
    repeat (4) rd(3, 0);
    idle();

    // lw $5 then readers of rt = 5
    wr(5, 1);
    repeat (3) rd(0, 5);
    idle();

    // writes to $0 never create a dependency
    wr(0, 0);
    rd(0, 0);
    rd(0, 0);

    // taken branch, second pulse lands inside flush
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    idle();

    // RAW hazard coinciding with a taken branch
    wr(7, 0);
    step(0, 1, 7, 0, 1, 0, 1, 9, 0, 1, 0);
    idle();
    rd(9, 9);
    repeat (3) idle();

    // reset in the middle of a flush with live entries
    wr(1, 0);
    wr(2, 1);
    wr(4, 0);
    step(0, 1, 0, 0, 0, 0, 1, 6, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    rd(1, 2);

    // counter saturation and clear
    repeat (3) begin
      wr(6, 0);
      repeat (4) rd(6, 6);
    end
    repeat (3) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle();
      idle();
    end
    repeat (6) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle();
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 8),
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom),
           ($urandom_range(0, 9) < 6),
           int'($urandom_range(0, 7)),
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 39) == 0));
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    chk("drain", cyc, 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
